jpeg_quantizer_stream: RTL and testbench



---
 rtl/jpeg_quantizer_stream.sv | 187 ++++++++++++++++++
 tb/tb_jpeg_quantizer_stream.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_quantizer_stream.sv
// Streaming JPEG quantizer: one coefficient per cycle, 3-stage pipeline, runtime reciprocal tables.
// Define QUANT_SAT_EN to clamp out-of-range results and enable the sticky sat_flag.
module jpeg_quantizer_stream #(
  parameter int IN_W    = 11,
  parameter int OUT_W   = 11,
  parameter int RECIP_W = 13,
  parameter int FRAC_W  = 12,
  parameter int NUM_CH  = 3,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic [CH_W-1:0]    in_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [5:0]         out_index,
  output logic               out_last,
  input  logic               tbl_we,
  input  logic [CH_W-1:0]    tbl_ch,
  input  logic [5:0]         tbl_addr,
  input  logic [RECIP_W-1:0] tbl_data,
  output logic               sat_flag
);

  localparam int MAG_W = IN_W + 1;
  localparam int M_W   = MAG_W + RECIP_W;
  localparam int R_W   = M_W + 1 - FRAC_W;
  localparam int RS_W  = R_W + 1;
  localparam logic [M_W:0] HALF = (M_W + 1)'(2 ** (FRAC_W - 1));

  // Standard JPEG luminance / chrominance quantizer steps, raster order
  localparam logic [0:63][7:0] LUMA_Q = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };
  localparam logic [0:63][7:0] CHROMA_Q = {
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  function automatic logic [RECIP_W-1:0] recip_of(input int q);
    return RECIP_W'(((2 ** FRAC_W) + q / 2) / q);
  endfunction

  logic [RECIP_W-1:0] tbl [NUM_CH * 64];

  // Tables are flops rather than RAM so that reset can restore the default reciprocals
  for (genvar gi = 0; gi < NUM_CH * 64; gi++) begin : g_tbl
    localparam int ENT = gi % 64;
    localparam int QV = (gi < 64) ? int'(LUMA_Q[ENT]) : int'(CHROMA_Q[ENT]);
    localparam logic [RECIP_W-1:0] INIT = recip_of(QV);
    localparam logic [CH_W-1:0] ENT_CH = CH_W'(gi / 64);
    localparam logic [5:0] ENT_ADDR = 6'(ENT);
    logic [RECIP_W-1:0] ent_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        ent_reg <= INIT;
      end else if (tbl_we && tbl_ch == ENT_CH && tbl_addr == ENT_ADDR) begin
        ent_reg <= tbl_data;
      end
    end
    assign tbl[gi] = ent_reg;
  end

  logic               advance;
  logic [5:0]         blk_idx_reg;
  logic [CH_W-1:0]    ch_reg;
  logic [CH_W-1:0]    in_ch_sel;
  logic [CH_W-1:0]    rd_ch;
  logic [CH_W+5:0]    rd_addr;

  logic               s1_valid_reg;
  logic [IN_W-1:0]    s1_data_reg;
  logic [5:0]         s1_idx_reg;
  logic [RECIP_W-1:0] s1_recip_reg;
  logic signed [MAG_W-1:0] s1_ext;
  logic [MAG_W-1:0]   s1_mag;

  logic               s2_valid_reg;
  logic [M_W-1:0]     s2_m_reg;
  logic               s2_neg_reg;
  logic [5:0]         s2_idx_reg;

  logic [M_W:0]       rnd_sum;
  logic [R_W-1:0]     r_mag;
  logic [RS_W-1:0]    res_mag;
  logic signed [RS_W-1:0] res;
  logic [OUT_W-1:0]   res_out;
  logic               unused_bits;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign in_ch_sel = (int'(in_ch) < NUM_CH) ? in_ch : '0;
  // Coefficient 0 reads with the live select; the rest of the block uses the latched one
  assign rd_ch     = (blk_idx_reg == 6'd0) ? in_ch_sel : ch_reg;
  assign rd_addr   = {rd_ch, blk_idx_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      blk_idx_reg  <= 6'd0;
      ch_reg       <= '0;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      out_valid    <= s2_valid_reg;
      if (in_valid) begin
        blk_idx_reg <= blk_idx_reg + 6'd1;
        if (blk_idx_reg == 6'd0) ch_reg <= in_ch_sel;
      end
    end
  end

  assign s1_ext = MAG_W'($signed(s1_data_reg));
  assign s1_mag = s1_ext[MAG_W-1] ? MAG_W'(-s1_ext) : MAG_W'(s1_ext);

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_data_reg  <= in_data;
      s1_idx_reg   <= blk_idx_reg;
      s1_recip_reg <= tbl[rd_addr];
      s2_m_reg     <= M_W'(s1_mag) * M_W'(s1_recip_reg);
      s2_neg_reg   <= s1_data_reg[IN_W-1];
      s2_idx_reg   <= s1_idx_reg;
    end
  end

  assign rnd_sum = {1'b0, s2_m_reg} + HALF;
  assign r_mag   = rnd_sum[M_W:FRAC_W];
  assign res_mag = {1'b0, r_mag};
  assign res     = s2_neg_reg ? -$signed(res_mag) : $signed(res_mag);

`ifdef QUANT_SAT_EN
  localparam logic signed [RS_W-1:0] MAX_V = RS_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RS_W-1:0] MIN_V = RS_W'(-(2 ** (OUT_W - 1)));
  logic res_hi;
  logic res_lo;
  assign res_hi  = res > MAX_V;
  assign res_lo  = res < MIN_V;
  assign res_out = res_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                   res_lo ? {1'b1, {(OUT_W-1){1'b0}}} : res[OUT_W-1:0];
  assign unused_bits = ^rnd_sum[FRAC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (advance && s2_valid_reg && (res_hi || res_lo)) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign res_out     = res[OUT_W-1:0];
  assign unused_bits = ^{rnd_sum[FRAC_W-1:0], res[RS_W-1:OUT_W]};
  assign sat_flag    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_index <= 6'd0;
      out_last  <= 1'b0;
    end else if (advance && s2_valid_reg) begin
      out_data  <= res_out;
      out_index <= s2_idx_reg;
      out_last  <= (s2_idx_reg == 6'd63);
    end
  end

endmodule

// File: tb/tb_jpeg_quantizer_stream.sv
// Scoreboard bench for jpeg_quantizer_stream: directed blocks, stalls, mid-block reset, table writes.
module tb_jpeg_quantizer_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic [1:0]  in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [5:0]  out_index;
  logic        out_last;
  logic        tbl_we;
  logic [1:0]  tbl_ch;
  logic [5:0]  tbl_addr;
  logic [12:0] tbl_data;
  logic        sat_flag;

  always #5 clk = ~clk;

  jpeg_quantizer_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .tbl_we(tbl_we), .tbl_ch(tbl_ch),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .sat_flag(sat_flag)
  );

  typedef struct {
    int   data;
    int   idx;
    bit   last;
    bit   sat;
    int   acc;
    bit   lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   idx_model = 0;
  bit   sat_sticky = 1'b0;
  bit   stall_go = 1'b0;
  int   shadow [3][64];

  int luma_q [64] = '{16, 11, 10, 16, 24, 40, 51, 61, 12, 12, 14, 19, 26, 58, 60, 55,
                      14, 13, 16, 24, 40, 57, 69, 56, 14, 17, 22, 29, 51, 87, 80, 62,
                      18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
                      49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
  int chroma_q [64] = '{17, 18, 24, 47, 99, 99, 99, 99, 18, 21, 26, 66, 99, 99, 99, 99,
                        24, 26, 56, 99, 99, 99, 99, 99, 47, 66, 99, 99, 99, 99, 99, 99,
                        99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99,
                        99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99};

`ifdef QUANT_SAT_EN
  localparam int SAT_EXP = -1024;
  localparam bit SAT_HIT = 1'b1;
`else
  localparam int SAT_EXP = 0;
  localparam bit SAT_HIT = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic void init_shadow();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 64; i++) begin
        int q;
        q = (c == 0) ? luma_q[i] : chroma_q[i];
        shadow[c][i] = (4096 + q / 2) / q;
      end
  endfunction

  function automatic int qmodel(input int c, input int recip, output bit sat);
    longint m;
    int r;
    int res;
    m = longint'((c < 0) ? -c : c) * longint'(recip);
    r = int'((m + 2048) >> 12);
    res = (c < 0) ? -r : r;
    sat = 1'b0;
`ifdef QUANT_SAT_EN
    if (res > 1023) begin
      res = 1023;
      sat = 1'b1;
    end else if (res < -1024) begin
      res = -1024;
      sat = 1'b1;
    end
`else
    res = ((res + 1024) & 2047) - 1024;
`endif
    return res;
  endfunction

  task automatic send(input int coef, input int ch_drive, input int exp_v, input bit sat_hit, input bit lat);
    int waits;
    exp_t e;
    waits = 0;
    in_valid = 1'b1;
    in_data = 11'(coef);
    in_ch = 2'(ch_drive);
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", waits);
    end else begin
      if (sat_hit) sat_sticky = 1'b1;
      e.data = exp_v;
      e.idx = idx_model;
      e.last = (idx_model == 63);
      e.sat = sat_sticky;
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
      $display("in  idx=%0d coef=%0d ch=%0d expect=%0d", idx_model, coef, ch_drive, exp_v);
      idx_model = (idx_model + 1) % 64;
      if (lat) check("in_ready_waits", waits, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic write_tbl(input int ch, input int addr, input int val);
    tbl_we = 1'b1;
    tbl_ch = 2'(ch);
    tbl_addr = 6'(addr);
    tbl_data = 13'(val);
    @(posedge clk);
    #1;
    tbl_we = 1'b0;
    if (ch < 3) shadow[ch][addr] = val;
  endtask

  task automatic block(input int ch, input int seed, input int ov_idx, input int ov_coef,
                       input int ov_exp, input int alt_at, input int alt_ch, input int stall_at,
                       input int wr_idx, input int wr_val, input int stop_at, input bit lat);
    int tch;
    int c;
    int ev;
    bit s;
    tch = (ch < 3) ? ch : 0;
    for (int i = 0; i < 64; i++) begin
      if (i == stop_at) break;
      c = ((i * 173 + seed * 31) % 2047) - 1023;
      ev = qmodel(c, shadow[tch][i], s);
      if (i == ov_idx) begin
        c = ov_coef;
        ev = ov_exp;
        s = 1'b0;
      end
      if (i == stall_at) stall_go = 1'b1;
      if (i == wr_idx) begin
        tbl_we = 1'b1;
        tbl_ch = 2'(tch);
        tbl_addr = 6'(i);
        tbl_data = 13'(wr_val);
      end
      send(c, (alt_at >= 0 && i >= alt_at) ? alt_ch : ch, ev, s, lat);
      if (i == wr_idx) begin
        tbl_we = 1'b0;
        shadow[tch][i] = wr_val;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: out_valid with index %0d, expected no output", out_index);
        end else begin
          e = sb.pop_front();
          $display("out idx=%0d data=%0d expect=%0d", out_index, $signed(out_data), e.data);
          check("out_data", int'($signed(out_data)), e.data);
          check("out_index", int'(out_index), e.idx);
          check("out_last", int'(out_last), int'(e.last));
          check("sat_flag", int'(sat_flag), int'(e.sat));
          if (e.lat) check("latency", cyc - e.acc, 3);
        end
      end
    end
  end

  // Stall injector: holds out_ready low for five cycles when requested
  initial begin
    wait (stall_go);
    stall_go = 1'b0;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_ch = '0;
    out_ready = 1'b1;
    tbl_we = 1'b0;
    tbl_ch = '0;
    tbl_addr = '0;
    tbl_data = '0;
    init_shadow();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_index", int'(out_index), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Full luma block, free-running output, latency checked on every item
    block(0, 0, -1, 0, 0, -1, 0, -1, -1, 0, -1, 1'b1);
    drain();

    // Q=16 on ch1 entry 0, round half away from zero; stall mid-block; write racing a read
    write_tbl(1, 0, 256);
    block(1, 1, 0, 100, 6, -1, 0, -1, -1, 0, -1, 1'b0);
    block(1, 2, 0, -100, -6, -1, 0, 20, -1, 0, -1, 1'b0);
    block(1, 3, 0, 40, 3, -1, 0, -1, -1, 0, -1, 1'b0);
    block(1, 4, 0, -40, -3, -1, 0, -1, 10, 4096, -1, 1'b0);

    // Q=1 on ch2 entry 5, extreme inputs
    write_tbl(2, 5, 4096);
    block(2, 5, 5, 1023, 1023, -1, 0, -1, -1, 0, -1, 1'b0);
    block(2, 6, 5, -1024, -1024, -1, 0, -1, -1, 0, -1, 1'b0);

    // Out-of-range channel: write dropped, select falls back to table 0
    write_tbl(3, 0, 4096);
    block(3, 7, 0, 1000, 63, -1, 0, -1, -1, 0, -1, 1'b0);
    drain();

    // in_ch change at 30 ignored, reset at 40 discards in-flight data
    block(1, 8, -1, 0, 0, 30, 0, -1, -1, 0, 40, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    sb.delete();
    idx_model = 0;
    sat_sticky = 1'b0;
    init_shadow();
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_index", int'(out_index), 0);
    check("midrst_out_last", int'(out_last), 0);
    repeat (3) begin
      @(negedge clk);
      check("idle_out_valid", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    block(1, 9, 0, 400, 24, -1, 0, -1, -1, 0, -1, 1'b0);
    block(2, 10, 5, 1023, 10, -1, 0, -1, -1, 0, -1, 1'b0);
    drain();

    // Overflowing product: clamp with flag, or wrap to zero
    write_tbl(0, 0, 8191);
    send(-1024, 0, SAT_EXP, SAT_HIT, 1'b0);
    drain();
    check("sat_flag_final", int'(sat_flag), int'(sat_sticky));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
